// File: rtl/bp_fe_cache_req_arbiter.sv
// Round-robin arbiter sharing one LCE cache-request channel between two requesters.
// One miss outstanding at a time; metadata and completion are steered to the miss owner.
//
// state           | meaning
// ----------------+-------------------------------------------------------------
// e_ready         | no miss in flight; grant a valid requester to the LCE
// e_wait_meta     | miss accepted; forwarding owner's metadata until it is valid
// e_wait_complete | metadata delivered; waiting for the LCE to finish the miss
module bp_fe_cache_req_arbiter #(
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [req_width_p-1:0]      req0_i,
  input  logic                        req0_v_i,
  output logic                        req0_ready_o,
  input  logic [metadata_width_p-1:0] req0_metadata_i,
  input  logic                        req0_metadata_v_i,
  output logic                        req0_complete_o,

  input  logic [req_width_p-1:0]      req1_i,
  input  logic                        req1_v_i,
  output logic                        req1_ready_o,
  input  logic [metadata_width_p-1:0] req1_metadata_i,
  input  logic                        req1_metadata_v_i,
  output logic                        req1_complete_o,

  output logic [req_width_p-1:0]      cache_req_o,
  output logic                        cache_req_v_o,
  input  logic                        cache_req_ready_i,
  output logic [metadata_width_p-1:0] cache_req_metadata_o,
  output logic                        cache_req_metadata_v_o,
  input  logic                        cache_req_complete_i
);

  typedef enum logic [1:0] {
    e_ready         = 2'd0,
    e_wait_meta     = 2'd1,
    e_wait_complete = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;

  logic                        grant;
  logic                        any_v;
  logic                        owner_meta_v;
  logic [metadata_width_p-1:0] owner_meta;

  // A lone valid requester wins; on a tie the one not granted last time wins.
  assign any_v = req0_v_i | req1_v_i;
  assign grant = req1_v_i & (~req0_v_i | ~last_grant_q);

  assign owner_meta_v = owner_q ? req1_metadata_v_i : req0_metadata_v_i;
  assign owner_meta   = owner_q ? req1_metadata_i   : req0_metadata_i;

  always_comb begin
    state_d                = state_q;
    owner_d                = owner_q;
    last_grant_d           = last_grant_q;
    cache_req_o            = '0;
    cache_req_v_o          = 1'b0;
    cache_req_metadata_o   = '0;
    cache_req_metadata_v_o = 1'b0;
    req0_ready_o           = 1'b0;
    req1_ready_o           = 1'b0;
    req0_complete_o        = 1'b0;
    req1_complete_o        = 1'b0;

    if (!reset_i) begin
      unique case (state_q)
        e_ready: begin
          cache_req_v_o = any_v;
          if (any_v) begin
            cache_req_o = grant ? req1_i : req0_i;
          end
          req0_ready_o = any_v & ~grant & cache_req_ready_i;
          req1_ready_o = any_v &  grant & cache_req_ready_i;
          if (any_v && cache_req_ready_i) begin
            owner_d      = grant;
            last_grant_d = grant;
            state_d      = e_wait_meta;
          end
        end

        e_wait_meta: begin
          cache_req_metadata_v_o = owner_meta_v;
          cache_req_metadata_o   = owner_meta;
          // An early completion ends the miss even if metadata never arrived.
          if (cache_req_complete_i) begin
            req0_complete_o = ~owner_q;
            req1_complete_o =  owner_q;
            state_d         = e_ready;
          end else if (owner_meta_v) begin
            state_d = e_wait_complete;
          end
        end

        e_wait_complete: begin
          if (cache_req_complete_i) begin
            req0_complete_o = ~owner_q;
            req1_complete_o =  owner_q;
            state_d         = e_ready;
          end
        end

        default: begin
          state_d = e_ready;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_ready;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_bp_fe_cache_req_arbiter.sv
// Bench for bp_fe_cache_req_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_bp_fe_cache_req_arbiter;
  localparam int RW = 64;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] req0, req1;
  logic          req0_v, req1_v;
  logic [MW-1:0] req0_md, req1_md;
  logic          req0_md_v, req1_md_v;
  logic          cache_req_ready, cplt;

  logic          req0_ready_o, req1_ready_o, req0_complete_o, req1_complete_o;
  logic [RW-1:0] cache_req_o;
  logic          cache_req_v_o;
  logic [MW-1:0] cache_req_metadata_o;
  logic          cache_req_metadata_v_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_fe_cache_req_arbiter #(.req_width_p(RW), .metadata_width_p(MW)) dut (
    .clk_i                  (clk),
    .reset_i                (reset),
    .req0_i                 (req0),
    .req0_v_i               (req0_v),
    .req0_ready_o           (req0_ready_o),
    .req0_metadata_i        (req0_md),
    .req0_metadata_v_i      (req0_md_v),
    .req0_complete_o        (req0_complete_o),
    .req1_i                 (req1),
    .req1_v_i               (req1_v),
    .req1_ready_o           (req1_ready_o),
    .req1_metadata_i        (req1_md),
    .req1_metadata_v_i      (req1_md_v),
    .req1_complete_o        (req1_complete_o),
    .cache_req_o            (cache_req_o),
    .cache_req_v_o          (cache_req_v_o),
    .cache_req_ready_i      (cache_req_ready),
    .cache_req_metadata_o   (cache_req_metadata_o),
    .cache_req_metadata_v_o (cache_req_metadata_v_o),
    .cache_req_complete_i   (cplt)
  );

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_v = 0; req1_v = 0; req0_md_v = 0; req1_md_v = 0;
    cache_req_ready = 0; cplt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    adv();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    reset = 1;
    req0 = {$urandom, $urandom}; req1 = {$urandom, $urandom};
    req0_v = 1; req1_v = 1; cache_req_ready = 1;
    req0_md = 8'h5A; req1_md = 8'hA5; req0_md_v = 1; req1_md_v = 1; cplt = 1;
    @(negedge clk);
    obs = {req0_ready_o, req1_ready_o, cache_req_v_o, cache_req_metadata_v_o,
           req0_complete_o, req1_complete_o};
    total++;
    if (obs !== 6'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 000000", obs); end
    total++;
    if (cache_req_o !== '0) begin bad++; $display("FAIL reset_req: got %h want 0", cache_req_o); end
    total++;
    if (cache_req_metadata_o !== '0) begin
      bad++; $display("FAIL reset_meta: got %h want 0", cache_req_metadata_o);
    end
    adv();
    reset = 0;
    idle_inputs();
    req0_v = 1; req1_v = 1;
    @(negedge clk);
    total++;
    if (cache_req_o !== req0) begin
      bad++; $display("FAIL reset_pref: got %h want %h", cache_req_o, req0);
    end
    adv();
    idle_inputs();
  endtask

  task automatic test_single_miss();
    idle_inputs();
    req0 = {$urandom, $urandom};
    req0_v = 1; cache_req_ready = 1;
    @(negedge clk);
    total++;
    if ({req0_ready_o, req1_ready_o, cache_req_v_o} !== 3'b101) begin
      bad++; $display("FAIL single_ready: got %b want 101", {req0_ready_o, req1_ready_o, cache_req_v_o});
    end
    total++;
    if (cache_req_o !== req0) begin bad++; $display("FAIL single_pkt: got %h want %h", cache_req_o, req0); end
    adv();
    req0_v = 0; req0_md = 8'h05; req0_md_v = 1;
    @(negedge clk);
    total++;
    if ({cache_req_metadata_v_o, cache_req_metadata_o} !== {1'b1, 8'h05}) begin
      bad++; $display("FAIL single_meta: got %b/%h want 1/05", cache_req_metadata_v_o, cache_req_metadata_o);
    end
    adv();
    req0_md_v = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      total++;
      if ({req0_complete_o, req1_complete_o, cache_req_metadata_v_o} !== 3'b000) begin
        bad++; $display("FAIL single_quiet: cycle %0d got %b want 000", i,
                        {req0_complete_o, req1_complete_o, cache_req_metadata_v_o});
      end
      adv();
    end
    cplt = 1;
    @(negedge clk);
    total++;
    if ({req0_complete_o, req1_complete_o} !== 2'b10) begin
      bad++; $display("FAIL single_cplt: got %b want 10", {req0_complete_o, req1_complete_o});
    end
    adv();
    cplt = 0;
    @(negedge clk);
    total++;
    if ({req0_complete_o, req1_complete_o} !== 2'b00) begin
      bad++; $display("FAIL single_pulse: got %b want 00", {req0_complete_o, req1_complete_o});
    end
    adv();
  endtask

  task automatic test_round_robin();
    logic exp_g;
    logic [1:0] exp_sel;
    do_reset();
    req0 = {$urandom, $urandom}; req1 = {$urandom, $urandom};
    req0_v = 1; req1_v = 1; cache_req_ready = 1;
    for (int m = 0; m < 4; m++) begin
      exp_g   = (m % 2) == 1;
      exp_sel = exp_g ? 2'b10 : 2'b01;
      @(negedge clk);
      total++;
      if ({req1_ready_o, req0_ready_o} !== exp_sel) begin
        bad++; $display("FAIL rr_grant: miss %0d got %b want %b", m, {req1_ready_o, req0_ready_o}, exp_sel);
      end
      total++;
      if (cache_req_o !== (exp_g ? req1 : req0)) begin
        bad++; $display("FAIL rr_pkt: miss %0d got %h", m, cache_req_o);
      end
      adv();
      if (exp_g) begin req1 = {$urandom, $urandom}; req1_md_v = 1; req1_md = 8'h11; end
      else begin req0 = {$urandom, $urandom}; req0_md_v = 1; req0_md = 8'h22; end
      @(negedge clk);
      total++;
      if ({req1_ready_o, req0_ready_o, cache_req_v_o} !== 3'b000) begin
        bad++; $display("FAIL rr_busy_meta: miss %0d got %b want 000", m,
                        {req1_ready_o, req0_ready_o, cache_req_v_o});
      end
      adv();
      req0_md_v = 0; req1_md_v = 0;
      @(negedge clk);
      total++;
      if ({req1_ready_o, req0_ready_o, cache_req_v_o} !== 3'b000) begin
        bad++; $display("FAIL rr_busy_cplt: miss %0d got %b want 000", m,
                        {req1_ready_o, req0_ready_o, cache_req_v_o});
      end
      adv();
      cplt = 1;
      @(negedge clk);
      total++;
      if ({req1_complete_o, req0_complete_o} !== exp_sel) begin
        bad++; $display("FAIL rr_cplt: miss %0d got %b want %b", m, {req1_complete_o, req0_complete_o}, exp_sel);
      end
      adv();
      cplt = 0;
    end
    idle_inputs();
  endtask

  task automatic test_meta_filter();
    idle_inputs();
    req1 = {$urandom, $urandom};
    req1_v = 1; cache_req_ready = 1;
    @(negedge clk);
    total++;
    if (req1_ready_o !== 1'b1) begin bad++; $display("FAIL filt_grant: got %b want 1", req1_ready_o); end
    adv();
    req1_v = 0; req0_md = 8'hFF; req0_md_v = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (cache_req_metadata_v_o !== 1'b0) begin
        bad++; $display("FAIL filt_other: cycle %0d got %b want 0", i, cache_req_metadata_v_o);
      end
      adv();
    end
    req1_md = 8'h3C; req1_md_v = 1;
    @(negedge clk);
    total++;
    if ({cache_req_metadata_v_o, cache_req_metadata_o} !== {1'b1, 8'h3C}) begin
      bad++; $display("FAIL filt_owner: got %b/%h want 1/3c", cache_req_metadata_v_o, cache_req_metadata_o);
    end
    adv();
    req0_md_v = 0; req1_md_v = 0; cplt = 1;
    @(negedge clk);
    total++;
    if ({req1_complete_o, req0_complete_o} !== 2'b10) begin
      bad++; $display("FAIL filt_cplt: got %b want 10", {req1_complete_o, req0_complete_o});
    end
    adv();
    idle_inputs();
  endtask

  task automatic test_meta_complete_same();
    idle_inputs();
    req0 = {$urandom, $urandom};
    req0_v = 1; cache_req_ready = 1;
    adv();
    req0_v = 0; req0_md = 8'hA7; req0_md_v = 1; cplt = 1;
    @(negedge clk);
    total++;
    if ({cache_req_metadata_v_o, cache_req_metadata_o, req0_complete_o, req1_complete_o}
        !== {1'b1, 8'hA7, 1'b1, 1'b0}) begin
      bad++; $display("FAIL same_cycle: got %b/%h/%b%b want 1/a7/10", cache_req_metadata_v_o,
                      cache_req_metadata_o, req0_complete_o, req1_complete_o);
    end
    adv();
    req0_md_v = 0; cplt = 0;
    req1 = {$urandom, $urandom}; req1_v = 1;
    @(negedge clk);
    total++;
    if (req1_ready_o !== 1'b1) begin bad++; $display("FAIL same_regrant: got %b want 1", req1_ready_o); end
    adv();
    req1_v = 0; cplt = 1;
    adv();
    idle_inputs();
  endtask

  task automatic test_reset_mid_miss();
    idle_inputs();
    req0 = {$urandom, $urandom}; req1 = {$urandom, $urandom};
    req0_v = 1; cache_req_ready = 1;
    adv();
    req0_v = 0; req0_md_v = 1;
    adv();
    req0_md_v = 0;
    reset = 1; cplt = 1;
    @(negedge clk);
    total++;
    if ({req0_complete_o, req1_complete_o} !== 2'b00) begin
      bad++; $display("FAIL rst_mid_pulse: got %b want 00", {req0_complete_o, req1_complete_o});
    end
    adv();
    reset = 0;
    @(negedge clk);
    total++;
    if ({req0_complete_o, req1_complete_o} !== 2'b00) begin
      bad++; $display("FAIL rst_mid_stray: got %b want 00", {req0_complete_o, req1_complete_o});
    end
    adv();
    cplt = 0; req0_v = 1; req1_v = 1;
    @(negedge clk);
    total++;
    if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
      bad++; $display("FAIL rst_mid_pref: got %b want 10", {req0_ready_o, req1_ready_o});
    end
    adv();
    req0_v = 0; req1_v = 0; cplt = 1;
    adv();
    idle_inputs();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    req1 = {$urandom, $urandom};
    req1_v = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({req1_ready_o, cache_req_v_o, cache_req_o} !== {1'b0, 1'b1, req1}) begin
        bad++; $display("FAIL bp_hold: cycle %0d got %b/%b/%h", i, req1_ready_o, cache_req_v_o, cache_req_o);
      end
      adv();
    end
    cache_req_ready = 1;
    @(negedge clk);
    total++;
    if (req1_ready_o !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", req1_ready_o); end
    adv();
    req1_v = 0; cplt = 1;
    adv();
    idle_inputs();
  endtask

  // Model: a miss is either absent, accepted awaiting metadata, or awaiting completion.
  task automatic test_random();
    bit            active, meta_seen, owner, pref, g, md_chk;
    bit            e_r0, e_r1, e_v, e_mv, e_c0, e_c1;
    logic [RW-1:0] e_pkt;
    logic [MW-1:0] e_md;
    logic [5:0]    exp_ctrl, obs_ctrl;
    do_reset();
    active = 0; meta_seen = 0; owner = 0; pref = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!req0_v && $urandom_range(0, 2) == 0) begin req0_v = 1; req0 = {$urandom, $urandom}; end
      if (!req1_v && $urandom_range(0, 2) == 0) begin req1_v = 1; req1 = {$urandom, $urandom}; end
      cache_req_ready = ($urandom_range(0, 3) != 0);
      req0_md_v = ($urandom_range(0, 3) == 0); req0_md = MW'($urandom);
      req1_md_v = ($urandom_range(0, 3) == 0); req1_md = MW'($urandom);
      cplt = ($urandom_range(0, 4) == 0);

      {e_r0, e_r1, e_v, e_mv, e_c0, e_c1} = '0;
      e_pkt = '0; e_md = '0; md_chk = 1; g = 0;
      if (!reset) begin
        if (!active) begin
          md_chk = 0;
          if (req0_v || req1_v) begin
            g     = (req0_v && req1_v) ? pref : req1_v;
            e_v   = 1;
            e_pkt = g ? req1 : req0;
            e_r0  = cache_req_ready && !g;
            e_r1  = cache_req_ready && g;
          end
        end else begin
          if (!meta_seen) begin
            e_mv = owner ? req1_md_v : req0_md_v;
            e_md = owner ? req1_md : req0_md;
          end
          e_c0 = cplt && !owner;
          e_c1 = cplt && owner;
        end
      end
      exp_ctrl = {e_r0, e_r1, e_v, e_mv, e_c0, e_c1};

      @(negedge clk);
      obs_ctrl = {req0_ready_o, req1_ready_o, cache_req_v_o, cache_req_metadata_v_o,
                  req0_complete_o, req1_complete_o};
      total++;
      if (obs_ctrl !== exp_ctrl) begin
        bad++; $display("FAIL rand_ctrl: cycle %0d got %b want %b", c, obs_ctrl, exp_ctrl);
      end
      if (reset || e_v) begin
        total++;
        if (cache_req_o !== e_pkt) begin
          bad++; $display("FAIL rand_pkt: cycle %0d got %h want %h", c, cache_req_o, e_pkt);
        end
      end
      if (md_chk) begin
        total++;
        if (cache_req_metadata_o !== e_md) begin
          bad++; $display("FAIL rand_meta: cycle %0d got %h want %h", c, cache_req_metadata_o, e_md);
        end
      end

      if (reset) begin
        active = 0; pref = 0;
      end else if (!active) begin
        if (e_r0 || e_r1) begin active = 1; meta_seen = 0; owner = g; pref = !g; end
      end else if (cplt) begin
        active = 0;
      end else if (!meta_seen && (owner ? req1_md_v : req0_md_v)) begin
        meta_seen = 1;
      end

      adv();
      if (e_r0) req0_v = 0;
      if (e_r1) req1_v = 0;
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    req0 = '0; req1 = '0; req0_md = '0; req1_md = '0;
    idle_inputs();
    adv();
    adv();
    test_reset();
    test_single_miss();
    test_round_robin();
    test_meta_filter();
    test_meta_complete_same();
    test_reset_mid_miss();
    test_backpressure();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
